// File: rtl/clk_div_pkg.sv
// Shared constants and state encoding for the clock divider and its monitor.
package clk_div_pkg;
  localparam int DIV_CNT_W    = 8;
  localparam int DIV_TIMEOUT  = 255;
  localparam int DIV_LOCK_CNT = 4;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} mon_state_e;
endpackage

// File: rtl/clk_edge_det.sv
// Registers the previous sample of a clk_ref-synchronous signal and flags its edges.
module clk_edge_det (
  input  logic clk_ref,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);
  logic d_q;

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) d_q <= 1'b0;
    else     d_q <= sig;
  end

  assign rise = sig & ~d_q;
  assign fall = ~sig & d_q;
endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of the divided clock in clk_ref cycles,
// reports lock on a stable ratio and a timeout when edges stop arriving.
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = DIV_CNT_W,
  parameter int TIMEOUT  = DIV_TIMEOUT,
  parameter int LOCK_CNT = DIV_LOCK_CNT
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_div_clk,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high_time,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_timeout
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK    = 4'(LOCK_CNT);

  mon_state_e       state;
  logic [CNT_W-1:0] cnt, hcnt, cnt_inc, hcnt_inc;
  logic [3:0]       match, match_nxt;
  logic             rise, unused_fall;

  clk_edge_det u_edge (
    .clk_ref (clk_ref),
    .rst     (rst),
    .sig     (i_div_clk),
    .rise    (rise),
    .fall    (unused_fall)
  );

  assign cnt_inc  = (cnt  == CNT_MAX) ? cnt  : cnt  + 1'b1;
  assign hcnt_inc = (hcnt == CNT_MAX) ? hcnt : hcnt + 1'b1;

  // match==0 marks the first measurement since ARM, which always counts as 1
  always_comb begin
    match_nxt = 4'd1;
    if (match != 4'd0 && cnt == o_period)
      match_nxt = (match >= LOCK) ? LOCK : match + 4'd1;
  end

  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      hcnt        <= '0;
      match       <= '0;
      o_period    <= '0;
      o_high_time <= '0;
      o_valid     <= 1'b0;
      o_locked    <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (!i_en) begin
        state     <= IDLE;
        cnt       <= '0;
        hcnt      <= '0;
        match     <= '0;
        o_locked  <= 1'b0;
        o_timeout <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= ARM;
            cnt   <= '0;
          end
          ARM, MEASURE: begin
            if (rise) begin
              if (state == MEASURE) begin
                o_period    <= cnt;
                o_high_time <= hcnt;
                o_valid     <= 1'b1;
                match       <= match_nxt;
                o_locked    <= (match_nxt == LOCK);
              end
              state     <= MEASURE;
              cnt       <= CNT_W'(1);
              hcnt      <= CNT_W'(1);
              o_timeout <= 1'b0;
            end else if (cnt == TMO) begin
              state     <= ARM;
              cnt       <= '0;
              match     <= '0;
              o_locked  <= 1'b0;
              o_timeout <= 1'b1;
            end else begin
              cnt <= cnt_inc;
              if (state == MEASURE && i_div_clk) hcnt <= hcnt_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: lock, ratio change, timeout, boundary period, reset/enable.
module tb_clk_div_monitor;
  localparam int TMO = 255;

  logic       clk_ref = 1'b0;
  logic       rst, i_en, i_div_clk;
  logic [7:0] o_period, o_high_time;
  logic       o_valid, o_locked, o_timeout;
  int         ncmp = 0;
  int         nerr = 0;
  int         nv;

  always #5 clk_ref = ~clk_ref;

  clk_div_monitor dut (
    .clk_ref     (clk_ref),
    .rst         (rst),
    .i_en        (i_en),
    .i_div_clk   (i_div_clk),
    .o_period    (o_period),
    .o_high_time (o_high_time),
    .o_valid     (o_valid),
    .o_locked    (o_locked),
    .o_timeout   (o_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic d);
    i_div_clk = d;
    @(posedge clk_ref);
    #1;
  endtask

  // One divided-clock period starting with a rise; checks the result of the previous period.
  task automatic pc(input int p, input int h, input logic ev, input int ep, input int eh,
                    input logic el);
    int cnt_v;
    step(1'b1);
    chk($sformatf("valid p%0d", p), 32'(o_valid), 32'(ev));
    if (ev) begin
      chk($sformatf("period p%0d", p), 32'(o_period), 32'(ep));
      chk($sformatf("high p%0d", p), 32'(o_high_time), 32'(eh));
    end
    chk($sformatf("locked p%0d", p), 32'(o_locked), 32'(el));
    chk($sformatf("timeout p%0d", p), 32'(o_timeout), 32'd0);
    cnt_v = 0;
    for (int i = 1; i < p; i++) begin
      step(i < h);
      cnt_v += int'(o_valid);
    end
    chk($sformatf("no mid valid p%0d", p), 32'(cnt_v), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " period"}, 32'(o_period), 32'd0);
    chk({tag, " high"}, 32'(o_high_time), 32'd0);
    chk({tag, " valid"}, 32'(o_valid), 32'd0);
    chk({tag, " locked"}, 32'(o_locked), 32'd0);
    chk({tag, " timeout"}, 32'(o_timeout), 32'd0);
  endtask

  initial begin
    rst = 1'b1; i_en = 1'b0; i_div_clk = 1'b0;
    repeat (2) @(posedge clk_ref);
    #1;
    chk_all_zero("reset");
    rst = 1'b0; i_en = 1'b1;
    step(1'b0);

    // div-by-4, 50% duty: lock on the 4th measurement
    pc(4, 2, 1'b0, 0, 0, 1'b0);
    for (int k = 1; k <= 4; k++) pc(4, 2, 1'b1, 4, 2, k == 4);

    // ratio change 4 -> 6: lock drops, then returns on the 4th period of 6
    pc(6, 3, 1'b1, 4, 2, 1'b1);
    for (int k = 1; k <= 4; k++) pc(6, 3, 1'b1, 6, 3, k == 4);

    // odd div-by-5, high 2
    pc(5, 2, 1'b1, 6, 3, 1'b1);
    for (int k = 1; k <= 4; k++) pc(5, 2, 1'b1, 5, 2, k == 4);

    // enable drop mid-measurement
    step(1'b1);
    chk("pre-dis valid", 32'(o_valid), 32'd1);
    chk("pre-dis locked", 32'(o_locked), 32'd1);
    step(1'b1);
    i_en = 1'b0;
    step(1'b0);
    chk("dis locked", 32'(o_locked), 32'd0);
    chk("dis valid", 32'(o_valid), 32'd0);
    chk("dis period hold", 32'(o_period), 32'd5);
    chk("dis high hold", 32'(o_high_time), 32'd2);

    // constant-low clock: timeout exactly TMO+1 cycles after entering ARM
    i_en = 1'b1;
    step(1'b0);
    nv = 0;
    repeat (TMO) begin
      step(1'b0);
      nv += int'(o_valid);
    end
    chk("tmo early", 32'(o_timeout), 32'd0);
    chk("tmo no valid", 32'(nv), 32'd0);
    step(1'b0);
    chk("tmo set", 32'(o_timeout), 32'd1);
    chk("tmo locked", 32'(o_locked), 32'd0);

    // first rise clears timeout without a measurement
    step(1'b1);
    chk("tmo clear", 32'(o_timeout), 32'd0);
    chk("tmo first rise valid", 32'(o_valid), 32'd0);
    step(1'b1); step(1'b0); step(1'b0);
    pc(4, 2, 1'b1, 4, 2, 1'b0);

    // period equal to TIMEOUT: measured, no timeout
    pc(TMO, 1, 1'b1, 4, 2, 1'b0);
    pc(4, 2, 1'b1, TMO, 1, 1'b0);
    for (int k = 1; k <= 4; k++) pc(4, 2, 1'b1, 4, 2, k == 4);

    // async reset mid-measurement while locked
    step(1'b1);
    chk("pre-rst locked", 32'(o_locked), 32'd1);
    step(1'b1);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async rst");
    @(posedge clk_ref);
    #1 rst = 1'b0;
    step(1'b0);
    chk("post-rst period", 32'(o_period), 32'd0);
    chk("post-rst locked", 32'(o_locked), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
